// File: rtl/sdram_line_port.sv
// sdram_line_port
// Single-line write-back / write-allocate buffer between the CPU word bus and
// the 256-bit line request interface of the SDRAM controller. One clock
// (memory clock), asynchronous active-low reset, all outputs registered.
//
// Ports
//   clk, resetn                 clock, async active-low reset
//   bus_addr[23:0]              word address ([23:3] line, [2:0] word)
//   bus_data[31:0], bus_we      write data / write enable, sampled with bus_start
//   bus_start, bus_flush        one-cycle request pulses (ignored while busy)
//   bus_done, bus_q[31:0]       completion pulse / read data (held until next done)
//   bus_busy                    high whenever the port is not idle
//   cpu_addr[20:0]              SDRAM line address
//   cpu_data[255:0], cpu_we     line write data / write strobe
//   cpu_start                   SDRAM request, held until cpu_done
//   cpu_done, cpu_q[255:0]      controller completion pulse / line read data
module sdram_line_port (
    input  logic         clk,
    input  logic         resetn,
    input  logic [23:0]  bus_addr,
    input  logic [31:0]  bus_data,
    input  logic         bus_we,
    input  logic         bus_start,
    input  logic         bus_flush,
    output logic         bus_done,
    output logic [31:0]  bus_q,
    output logic         bus_busy,
    output logic [20:0]  cpu_addr,
    output logic [255:0] cpu_data,
    output logic         cpu_we,
    output logic         cpu_start,
    input  logic         cpu_done,
    input  logic [255:0] cpu_q
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WB     = 3'd1;
    localparam logic [2:0] ST_WB_GAP = 3'd2;
    localparam logic [2:0] ST_FILL   = 3'd3;
    localparam logic [2:0] ST_RESP   = 3'd4;
    localparam logic [2:0] ST_FLUSH  = 3'd5;

    // Extract 32-bit word `sel` from a line.
    function automatic logic [31:0] word_get(input logic [255:0] line, input logic [2:0] sel);
        word_get = line[{sel, 5'd0} +: 32];
    endfunction

    // Replace 32-bit word `sel` of a line with `data`.
    function automatic logic [255:0] word_put(input logic [255:0] line, input logic [2:0] sel,
                                              input logic [31:0] data);
        logic [255:0] res;
        res = line;
        res[{sel, 5'd0} +: 32] = data;
        word_put = res;
    endfunction

    logic [2:0]   state_r;
    logic [2:0]   state_nxt_s;
    logic [255:0] line_buf_r;
    logic [20:0]  line_tag_r;
    logic         valid_r;
    logic         dirty_r;
    logic [23:0]  req_addr_r;
    logic [31:0]  req_data_r;
    logic         req_we_r;
    logic         hit_rd_r;     // pending request is a read hit: RESP loads bus_q
    logic         bus_done_r;
    logic [31:0]  bus_q_r;
    logic         bus_busy_r;
    logic [20:0]  cpu_addr_r;
    logic [255:0] cpu_data_r;
    logic         cpu_we_r;
    logic         cpu_start_r;

    logic         hit_s;
    logic [20:0]  cpu_addr_nxt_s;
    logic [255:0] cpu_data_nxt_s;
    logic         cpu_we_nxt_s;
    logic         cpu_start_nxt_s;

    assign hit_s = valid_r && (bus_addr[23:3] == line_tag_r);

    // Next-state decode.
    // RESP holds for one extra cycle on hits and clean flushes so bus_done
    // lands two cycles after the request; controller completions enter RESP
    // with bus_done already raised, giving done one cycle after cpu_done.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus_start) begin
                    if (hit_s) begin
                        state_nxt_s = ST_RESP;
                    end else if (valid_r && dirty_r) begin
                        state_nxt_s = ST_WB;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else if (bus_flush) begin
                    if (valid_r && dirty_r) begin
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        state_nxt_s = ST_RESP;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WB:     state_nxt_s = cpu_done ? ST_WB_GAP : ST_WB;
            ST_WB_GAP: state_nxt_s = ST_FILL;
            ST_FILL:   state_nxt_s = cpu_done ? ST_RESP : ST_FILL;
            ST_FLUSH:  state_nxt_s = cpu_done ? ST_RESP : ST_FLUSH;
            ST_RESP:   state_nxt_s = bus_done_r ? ST_IDLE : ST_RESP;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Controller-side outputs derived from the upcoming state so they are
    // registered and constant for the whole time cpu_start is high.
    always_comb begin
        cpu_start_nxt_s = 1'b0;
        cpu_we_nxt_s    = 1'b0;
        cpu_addr_nxt_s  = 21'd0;
        cpu_data_nxt_s  = 256'd0;
        case (state_nxt_s)
            ST_WB, ST_FLUSH: begin
                cpu_start_nxt_s = 1'b1;
                cpu_we_nxt_s    = 1'b1;
                cpu_addr_nxt_s  = line_tag_r;
                cpu_data_nxt_s  = line_buf_r;
            end
            ST_FILL: begin
                cpu_start_nxt_s = 1'b1;
                // Straight from IDLE the request is not latched yet.
                cpu_addr_nxt_s  = (state_r == ST_IDLE) ? bus_addr[23:3] : req_addr_r[23:3];
            end
            default: begin
                cpu_start_nxt_s = 1'b0;
            end
        endcase
    end

    // State, line buffer and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            line_buf_r  <= 256'd0;
            line_tag_r  <= 21'd0;
            valid_r     <= 1'b0;
            dirty_r     <= 1'b0;
            req_addr_r  <= 24'd0;
            req_data_r  <= 32'd0;
            req_we_r    <= 1'b0;
            hit_rd_r    <= 1'b0;
            bus_done_r  <= 1'b0;
            bus_q_r     <= 32'd0;
            bus_busy_r  <= 1'b0;
            cpu_addr_r  <= 21'd0;
            cpu_data_r  <= 256'd0;
            cpu_we_r    <= 1'b0;
            cpu_start_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            bus_busy_r  <= (state_nxt_s != ST_IDLE);
            cpu_start_r <= cpu_start_nxt_s;
            cpu_we_r    <= cpu_we_nxt_s;
            cpu_addr_r  <= cpu_addr_nxt_s;
            cpu_data_r  <= cpu_data_nxt_s;
            bus_done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus_start) begin
                        req_addr_r <= bus_addr;
                        req_data_r <= bus_data;
                        req_we_r   <= bus_we;
                        hit_rd_r   <= hit_s && !bus_we;
                        if (hit_s && bus_we) begin
                            line_buf_r <= word_put(line_buf_r, bus_addr[2:0], bus_data);
                            dirty_r    <= 1'b1;
                        end
                    end else if (bus_flush) begin
                        hit_rd_r <= 1'b0;
                    end
                end
                ST_WB, ST_FLUSH: begin
                    if (cpu_done) begin
                        dirty_r    <= 1'b0;
                        bus_done_r <= (state_r == ST_FLUSH);
                    end
                end
                ST_FILL: begin
                    if (cpu_done) begin
                        line_tag_r <= req_addr_r[23:3];
                        valid_r    <= 1'b1;
                        bus_done_r <= 1'b1;
                        if (req_we_r) begin
                            line_buf_r <= word_put(cpu_q, req_addr_r[2:0], req_data_r);
                            dirty_r    <= 1'b1;
                        end else begin
                            line_buf_r <= cpu_q;
                            bus_q_r    <= word_get(cpu_q, req_addr_r[2:0]);
                        end
                    end
                end
                ST_RESP: begin
                    if (!bus_done_r) begin
                        bus_done_r <= 1'b1;
                        if (hit_rd_r) begin
                            bus_q_r <= word_get(line_buf_r, req_addr_r[2:0]);
                        end
                    end
                end
                default: begin
                    bus_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus_done  = bus_done_r;
    assign bus_q     = bus_q_r;
    assign bus_busy  = bus_busy_r;
    assign cpu_addr  = cpu_addr_r;
    assign cpu_data  = cpu_data_r;
    assign cpu_we    = cpu_we_r;
    assign cpu_start = cpu_start_r;

endmodule

// File: doc/sdram_line_port.md
# sdram_line_port

Initiator side of the 256-bit SDRAM controller request interface (`cpu_addr`/`cpu_data`/`cpu_we`/`cpu_start`/`cpu_done`/`cpu_q`). It converts 32-bit word reads and writes from the CPU/bus side into full-line SDRAM transactions. It holds one 256-bit line buffer with write-back, write-allocate policy, and sits between the CPU memory bus and the SDRAM controller in the memory clock domain.

## Interface
- No parameters; widths fixed: 24-bit word address, 8 words per 256-bit line, 21-bit line address.
- `clk` in 1: single clock (memory clock); all logic on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `bus_addr` in 24: word address; `[23:3]` = line, `[2:0]` = word select.
- `bus_data` in 32: write data.
- `bus_we` in 1: 1 = write, 0 = read; sampled with `bus_start`.
- `bus_start` in 1: one-cycle request pulse.
- `bus_flush` in 1: one-cycle pulse requesting write-back of a dirty line.
- `bus_done` out 1: one-cycle completion pulse.
- `bus_q` out 32: read data, valid in the `bus_done` cycle and held until the next `bus_done`.
- `bus_busy` out 1: high whenever state ≠ IDLE.
- `cpu_addr` out 21: SDRAM line address.
- `cpu_data` out 256: line write data; word w occupies bits `[32w+31:32w]`.
- `cpu_we` out 1: SDRAM write.
- `cpu_start` out 1: SDRAM request, held high until `cpu_done`.
- `cpu_done` in 1: one-cycle completion pulse from the controller.
- `cpu_q` in 256: line read data, valid in the `cpu_done` cycle.

## Operation
- State held: `line_buf[255:0]`, `line_tag[20:0]`, `valid`, `dirty`, latched request (`req_addr`, `req_data`, `req_we`).
- States: IDLE, WB, WB_GAP, FILL, RESP, FLUSH.
- **IDLE, `bus_start`:** latch the request.
  - Hit (`valid && bus_addr[23:3]==line_tag`), read: `bus_q` ← selected word.
  - Hit, write: merge `bus_data` into the selected word and set `dirty`=1.
  - Either hit: go to RESP.
  - Miss with `valid && dirty`: go to WB.
  - Miss otherwise: go to FILL.
- **IDLE, `bus_flush`:** if `valid && dirty`, go to FLUSH; otherwise pulse `bus_done` via RESP.
- **Start/flush priority:** if `bus_start` and `bus_flush` are both high in IDLE, `bus_start` wins and the flush is dropped.
- **WB:** `cpu_start`=1, `cpu_we`=1, `cpu_addr`=`line_tag`, `cpu_data`=`line_buf`. On `cpu_done`: `dirty`=0, go to WB_GAP.
- **WB_GAP:** `cpu_start`=0 for exactly one cycle, then go to FILL.
- **FILL:** `cpu_start`=1, `cpu_we`=0, `cpu_addr`=`req_addr[23:3]`. On `cpu_done`:
  - `line_buf` ← `cpu_q`, `line_tag` ← `req_addr[23:3]`, `valid`=1.
  - If `req_we`: merge `req_data` into the captured line and set `dirty`=1.
  - Else: `bus_q` ← word `req_addr[2:0]` of `cpu_q`.
  - Go to RESP.
- **FLUSH:** same signalling as WB. On `cpu_done`: `dirty`=0, go to RESP.
- **RESP:** `bus_done`=1 for one cycle, return to IDLE, `cpu_start`=0.
- **While busy:** `bus_start` and `bus_flush` are ignored (no queueing). The bus side must wait for `bus_done`.
- **`cpu_done` outside WB/FILL/FLUSH:** ignored (covers a late completion after reset).
- **Controller handshake:** `cpu_addr`, `cpu_data`, `cpu_we` are stable for the whole time `cpu_start` is high. `cpu_start` is low for at least one cycle between two consecutive requests (the FILL→RESP→IDLE path also satisfies this).

## Timing
- **Reset (async assert, sync deassert internally not required):**
  - State = IDLE; `valid`=`dirty`=0; `line_buf`, `line_tag` = 0.
  - Outputs all 0: `bus_done`, `bus_q`, `bus_busy`, `cpu_start`, `cpu_we`, `cpu_addr`, `cpu_data`.
- **Reset mid-operation:** `cpu_start` drops immediately and the buffered line and any dirty data are discarded.
- **All outputs are registered.**
- **Hit latency:** `bus_start` in cycle T → `bus_done` in cycle T+2 (RESP state); `bus_busy` high in T+1.
- **Clean miss:** `cpu_start` rises in T+1 (FILL). `cpu_done` in cycle D → `bus_done` in D+1.
- **Dirty miss:** write-back `cpu_start` rises in T+1.
  - Write-back `cpu_done` in cycle W → `cpu_start` low in W+1 → fill `cpu_start` high in W+2.
  - Fill `cpu_done` in D → `bus_done` in D+1.
- **`bus_q`:** updated in the same edge that raises `bus_done`.

## Test plan
- **Cold read:** reset, read `0x000013` → FILL with `cpu_addr`=`0x000002`, `cpu_we`=0. Return `cpu_q` word3=`0x12345678` → `bus_q`=`0x12345678` with `bus_done` one cycle after `cpu_done`.
- **Read hit:** after the cold read, read `0x000010` → `bus_done` two cycles after `bus_start`, `bus_q`=word0 of the line, `cpu_start` never asserted.
- **Dirty eviction:** write `0xDEADBEEF` to `0x000011` (hit, `dirty`=1), then read `0x000100`.
  - WB: `cpu_addr`=2, `cpu_we`=1, `cpu_data[63:32]`=`0xDEADBEEF`.
  - One-cycle `cpu_start` gap.
  - FILL: `cpu_addr`=`0x000020`.
- **Write miss allocate:** write `0x0000CAFE` to `0x0000FF` on a clean line → FILL `cpu_addr`=`0x00001F`. A following read of `0x0000FF` hits with `bus_q`=`0x0000CAFE`; flush then writes `cpu_data[255:224]`=`0x0000CAFE`.
- **Busy / flush:**
  - `bus_start` pulsed while in FILL → ignored: exactly one `bus_done`, one SDRAM request.
  - `bus_flush` with a clean line → `bus_done` in T+2, no `cpu_start`.
- **Reset mid-fill:** drop `resetn` while `cpu_start`=1 → all outputs 0 immediately. A later `cpu_done` is ignored. The next read of the same line misses and refills.
